// File: rtl/fetch_stage.sv
//==============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Drives the instruction-memory address
//               from the PC, captures returned words into the IF/ID register,
//               holds one response in a skid register while decode stalls, and
//               inserts two bubbles on every control-flow redirect.
//               Optional performance counters are enabled by defining the
//               macro FETCH_PERF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_stage #(
    parameter int               ISIZE    = 16,
    parameter int               ASIZE    = 16,
    parameter logic [ASIZE-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    // instruction memory
    output logic [ASIZE-1:0] imem_addr,
    output logic             imem_req,
    input  logic [ISIZE-1:0] imem_rdata,
    input  logic             imem_ready,
    // pipeline control
    input  logic             stall,
    input  logic             redirect,
    input  logic [ASIZE-1:0] redirect_pc,
    // IF/ID register
    output logic [ISIZE-1:0] instr,
    output logic             instr_valid,
    output logic [ISIZE-1:0] last_instr,
    output logic [ASIZE-1:0] pc_plus1
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]      perf_fetched,
    output logic [15:0]      perf_stall
`endif
);

    // FSM encoding: WAIT requests, BUF holds a response, FLUSH is the
    // second bubble after a redirect.
    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_BUF   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [ASIZE-1:0] PC_ONE = {{(ASIZE-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,  state_d;
    logic [ASIZE-1:0] pc_q,     pc_d;
    logic [ISIZE-1:0] skid_q,   skid_d;
    logic [ISIZE-1:0] instr_q,  instr_d;
    logic [ISIZE-1:0] last_q,   last_d;
    logic             valid_q,  valid_d;
    logic [ASIZE-1:0] pcp1_q,   pcp1_d;

    logic [ASIZE-1:0] w_pc_inc;

    // PC increment wraps naturally at 2^ASIZE
    assign w_pc_inc = pc_q + PC_ONE;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect overrides everything, including stall
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = S_FLUSH;
        end else begin
            case (state_q)
                S_WAIT:  if (imem_ready && stall) state_d = S_BUF;
                S_BUF:   if (!stall)              state_d = S_WAIT;
                S_FLUSH:                          state_d = S_WAIT;
                default:                          state_d = S_WAIT;
            endcase
        end
    end

    // Output logic: a request is outstanding only while waiting for memory
    always_comb begin
        imem_req = (state_q == S_WAIT);
    end

    // Datapath next-state: PC, skid register and IF/ID register
    always_comb begin
        pc_d    = pc_q;
        skid_d  = skid_q;
        instr_d = instr_q;
        last_d  = last_q;
        valid_d = valid_q;
        pcp1_d  = pcp1_q;
        if (redirect) begin
            // Discard the skid contents and any same-cycle response; the
            // bubble has rd=0 so it can never match a forwarding source.
            pc_d    = redirect_pc;
            skid_d  = '0;
            last_d  = instr_q;
            instr_d = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (imem_ready) begin
                        pc_d = w_pc_inc;
                        if (stall) begin
                            // Decode is busy: park the word, IF/ID holds
                            skid_d = imem_rdata;
                        end else begin
                            last_d  = instr_q;
                            instr_d = imem_rdata;
                            valid_d = 1'b1;
                            pcp1_d  = w_pc_inc;
                        end
                    end else if (!stall) begin
                        last_d  = instr_q;
                        instr_d = '0;
                        valid_d = 1'b0;
                    end
                end
                S_BUF: begin
                    if (!stall) begin
                        // PC already points past the parked word, so it is
                        // the parked word's address plus one.
                        last_d  = instr_q;
                        instr_d = skid_q;
                        valid_d = 1'b1;
                        pcp1_d  = pc_q;
                    end
                end
                S_FLUSH: begin
                    last_d  = instr_q;
                    instr_d = '0;
                    valid_d = 1'b0;
                end
                default: begin
                    last_d  = instr_q;
                    instr_d = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            skid_q  <= '0;
            instr_q <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            pcp1_q  <= RESET_PC;
        end else begin
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            instr_q <= instr_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            pcp1_q  <= pcp1_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign last_instr  = last_q;
    assign pc_plus1    = pcp1_q;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched_q;
    logic [15:0] perf_stall_q;
    logic        w_load;

    // An IF/ID load happens on a direct accept or on draining the skid register
    assign w_load = !redirect &&
                    (((state_q == S_WAIT) && imem_ready && !stall) ||
                     ((state_q == S_BUF)  && !stall));

    // Saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (w_load && (perf_fetched_q != 16'hFFFF)) begin
                perf_fetched_q <= perf_fetched_q + 16'd1;
            end
            if (stall && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//==============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage: directed scenarios plus a
//               randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] last_instr;
    logic [15:0] pc_plus1;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
`endif

    logic [15:0] mem [0:65535];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    fetch_stage #(.ISIZE(16), .ASIZE(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .last_instr  (last_instr),
        .pc_plus1    (pc_plus1)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    // Drive one cycle of inputs, then return 1 time unit after the rising edge
    task automatic cyc(input logic rdy, input logic st, input logic rd, input logic [15:0] rp);
        imem_ready  = rdy;
        stall       = st;
        redirect    = rd;
        redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({instr, last_instr, instr_valid, pc_plus1, imem_addr, imem_req} !== {16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1})
            $display("FAIL reset_state: got i=%h l=%h v=%b p1=%h a=%h r=%b", instr, last_instr, instr_valid, pc_plus1, imem_addr, imem_req);
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_sequence();
        logic [15:0] exp_i [3];
        exp_i[0] = 16'h0123; exp_i[1] = 16'h1456; exp_i[2] = 16'h2789;
        n_checks++;
        if ({imem_addr, imem_req} !== {16'h0000, 1'b1})
            $display("FAIL seq_first_req: got a=%h r=%b exp a=0000 r=1", imem_addr, imem_req);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0, '0);
            n_checks++;
            if ({instr, last_instr, instr_valid, pc_plus1} !== {exp_i[k], (k == 0) ? 16'h0 : exp_i[(k == 0) ? 0 : k-1], 1'b1, 16'(k+1)})
                $display("FAIL seq_%0d: got i=%h l=%h v=%b p1=%h exp i=%h p1=%h", k, instr, last_instr, instr_valid, pc_plus1, exp_i[k], 16'(k+1));
            else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        cyc(1'b1, 1'b0, 1'b0, '0); // loads mem[3], PC -> 4
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0, '0);
            n_checks++;
            if ({instr, instr_valid, imem_addr, imem_req} !== {16'h0, 1'b0, 16'h0004, 1'b1})
                $display("FAIL wait_bubble_%0d: got i=%h v=%b a=%h r=%b exp i=0000 v=0 a=0004 r=1", k, instr, instr_valid, imem_addr, imem_req);
            else n_pass++;
        end
        cyc(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({instr, instr_valid, pc_plus1, imem_addr} !== {mem[4], 1'b1, 16'h0005, 16'h0005})
            $display("FAIL wait_resume: got i=%h v=%b p1=%h a=%h exp i=%h", instr, instr_valid, pc_plus1, imem_addr, mem[4]);
        else n_pass++;
    endtask

    task automatic test_stall();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0, '0);
            n_checks++;
            if ({instr, instr_valid, imem_req, imem_addr} !== {mem[4], 1'b1, 1'b0, 16'h0006})
                $display("FAIL stall_hold_%0d: got i=%h v=%b r=%b a=%h exp i=%h r=0 a=0006", k, instr, instr_valid, imem_req, imem_addr, mem[4]);
            else n_pass++;
        end
        cyc(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({instr, last_instr, instr_valid, pc_plus1, imem_addr, imem_req} !== {mem[5], mem[4], 1'b1, 16'h0006, 16'h0006, 1'b1})
            $display("FAIL stall_release: got i=%h l=%h p1=%h a=%h r=%b exp i=%h p1=0006 a=0006", instr, last_instr, pc_plus1, imem_addr, imem_req, mem[5]);
        else n_pass++;
    endtask

    task automatic test_redirect();
        cyc(1'b1, 1'b1, 1'b0, '0);           // mem[6] parked in skid
        cyc(1'b1, 1'b1, 1'b1, 16'h0040);     // redirect overrides stall
        n_checks++;
        if ({instr, instr_valid, last_instr, imem_addr, imem_req} !== {16'h0, 1'b0, mem[5], 16'h0040, 1'b0})
            $display("FAIL redir_bubble1: got i=%h v=%b l=%h a=%h r=%b exp a=0040 r=0", instr, instr_valid, last_instr, imem_addr, imem_req);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({instr, instr_valid, last_instr, imem_addr, imem_req} !== {16'h0, 1'b0, 16'h0, 16'h0040, 1'b1})
            $display("FAIL redir_bubble2: got i=%h v=%b l=%h a=%h r=%b exp a=0040 r=1", instr, instr_valid, last_instr, imem_addr, imem_req);
        else n_pass++;
        cyc(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({instr, instr_valid, pc_plus1} !== {mem[16'h0040], 1'b1, 16'h0041})
            $display("FAIL redir_target: got i=%h v=%b p1=%h exp i=%h p1=0041", instr, instr_valid, pc_plus1, mem[16'h0040]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        cyc(1'b0, 1'b0, 1'b1, 16'hFFFF);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({instr, pc_plus1, imem_addr} !== {mem[16'hFFFF], 16'h0000, 16'h0000})
            $display("FAIL wrap: got i=%h p1=%h a=%h exp i=%h p1=0000 a=0000", instr, pc_plus1, imem_addr, mem[16'hFFFF]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0);  // waiting, memory not ready
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({instr, last_instr, instr_valid, pc_plus1, imem_addr, imem_req} !== {16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1})
            $display("FAIL async_reset: got i=%h l=%h v=%b p1=%h a=%h r=%b", instr, last_instr, instr_valid, pc_plus1, imem_addr, imem_req);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, '0);
        n_checks++;
        if ({instr, pc_plus1, instr_valid} !== {mem[0], 16'h0001, 1'b1})
            $display("FAIL after_reset_fetch: got i=%h p1=%h v=%b exp i=%h p1=0001", instr, pc_plus1, instr_valid, mem[0]);
        else n_pass++;
    endtask

    // Randomized traffic against a model built from the fetch rules:
    // a queue of parked words and a count of owed bubbles.
    task automatic test_random();
        logic [15:0] m_pc, m_instr, m_last, m_pcp1, rp, word;
        logic        m_valid, rdy, st, rd, exp_req;
        logic [15:0] held [$];
        int          owe;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        m_pc = 16'h0; m_instr = 16'h0; m_last = 16'h0; m_pcp1 = 16'h0; m_valid = 1'b0;
        held.delete(); owe = 0;
        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(0, 3) != 0);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 15) == 0);
            rp  = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 2)) : 16'($urandom);
            exp_req = (held.size() == 0) && (owe == 0);
            n_checks++;
            if ({imem_req, imem_addr} !== {exp_req, m_pc})
                $display("FAIL rand_req cyc %0d: got r=%b a=%h exp r=%b a=%h", n, imem_req, imem_addr, exp_req, m_pc);
            else n_pass++;
            word = mem[m_pc];
            cyc(rdy, st, rd, rp);
            if (rd) begin
                held.delete();
                m_pc = rp;
                owe  = 1;
                m_last = m_instr; m_instr = 16'h0; m_valid = 1'b0;
            end else if (owe > 0) begin
                owe--;
                m_last = m_instr; m_instr = 16'h0; m_valid = 1'b0;
            end else if (held.size() > 0) begin
                if (!st) begin
                    m_last = m_instr; m_instr = held.pop_front(); m_valid = 1'b1; m_pcp1 = m_pc;
                end
            end else if (rdy) begin
                m_pc = m_pc + 16'd1;
                if (st) held.push_back(word);
                else begin
                    m_last = m_instr; m_instr = word; m_valid = 1'b1; m_pcp1 = m_pc;
                end
            end else if (!st) begin
                m_last = m_instr; m_instr = 16'h0; m_valid = 1'b0;
            end
            n_checks++;
            if ({instr, last_instr, instr_valid, pc_plus1} !== {m_instr, m_last, m_valid, m_pcp1})
                $display("FAIL rand_ifid cyc %0d: got i=%h l=%h v=%b p1=%h exp i=%h l=%h v=%b p1=%h",
                         n, instr, last_instr, instr_valid, pc_plus1, m_instr, m_last, m_valid, m_pcp1);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0123; mem[1] = 16'h1456; mem[2] = 16'h2789;
        test_reset();
        test_sequence();
        test_wait_states();
        test_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
